// File: rtl/fht_pkg.sv
// Shared FHT loader/unloader definitions: frame geometry, loader FSM
// encodings and the bit-reversal helper.
package fht_pkg;

    localparam int FHT_A_BIT   = 8;
    localparam int N           = 4 << FHT_A_BIT;
    localparam int START_RETRY = 4;

    localparam logic [2:0] ST_LOAD      = 3'd0;
    localparam logic [2:0] ST_FIRE      = 3'd1;
    localparam logic [2:0] ST_KICK      = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    // Reverse the low w bits of v; result is right-aligned.
    function automatic logic [31:0] bitrev(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] r;
        r = {<<{v}};
        return r >> (32 - w);
    endfunction

endpackage

// File: rtl/fht_bitrev_map.sv
// Sample index -> {bank, bank address} in bit-reversed order.
// Shared by the input loader and the output unloader.
import fht_pkg::*;

module fht_bitrev_map #(
    parameter int A_BIT = 8
) (
    input  logic [A_BIT+1:0] n,
    output logic [1:0]       bank,
    output logic [A_BIT-1:0] addr
);

    localparam int RW = A_BIT + 2;

    logic [RW-1:0] r;

    assign r    = RW'(bitrev(32'(n), RW));
    assign bank = r[A_BIT+1:A_BIT];
    assign addr = r[A_BIT-1:0];

endmodule

// File: rtl/fht_input_loader.sv
// Streams one FHT frame into the four bank RAMs in bit-reversed order,
// then kicks fht_control and holds off input until the transform ends.
import fht_pkg::*;

module fht_input_loader #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic             iFHT_RDY,
    output logic             oSTART,
    output logic [A_BIT-1:0] oADDR,
    output logic [D_BIT-1:0] oDATA,
    output logic [3:0]       oWE,
    output logic             oLOAD_OWN,
    output logic             oFRAME_DONE
);

    localparam int NW      = A_BIT + 2;
    localparam int RETRY_W = $clog2(START_RETRY);

    logic [2:0]         state;
    logic [NW-1:0]      n;
    logic [RETRY_W-1:0] retry_cnt;
    logic [1:0]         map_bank;
    logic [A_BIT-1:0]   map_addr;
    logic               accept;
    logic               last;

    fht_bitrev_map #(
        .A_BIT (A_BIT)
    ) u_map (
        .n    (n),
        .bank (map_bank),
        .addr (map_addr)
    );

    assign accept = iVALID & oREADY;
    assign last   = &n;

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state       <= ST_LOAD;
            n           <= '0;
            retry_cnt   <= '0;
            oREADY      <= 1'b0;
            oSTART      <= 1'b0;
            oWE         <= '0;
            oADDR       <= '0;
            oDATA       <= '0;
            oLOAD_OWN   <= 1'b1;
            oFRAME_DONE <= 1'b0;
        end else begin
            oWE         <= '0;
            oSTART      <= 1'b0;
            oFRAME_DONE <= 1'b0;

            if (accept) begin
                oWE   <= 4'b0001 << map_bank;
                oADDR <= map_addr;
                oDATA <= iDATA;
                n     <= n + NW'(1);
            end

            unique case (state)
                ST_LOAD: begin
                    if (accept && last) begin
                        oREADY <= 1'b0;
                        state  <= ST_FIRE;
                    end else begin
                        oREADY <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    oSTART    <= 1'b1;
                    oLOAD_OWN <= 1'b0;
                    state     <= ST_KICK;
                end
                ST_KICK: begin
                    retry_cnt <= RETRY_W'(1);
                    state     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!iFHT_RDY) begin
                        state <= ST_WAIT_DONE;
                    end else if (retry_cnt == RETRY_W'(START_RETRY - 1)) begin
                        // fht_control missed the kick; pulse again
                        oSTART    <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (iFHT_RDY) begin
                        oFRAME_DONE <= 1'b1;
                        oLOAD_OWN   <= 1'b1;
                        oREADY      <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fht_input_loader.sv
// Directed bench for fht_input_loader: bit-reversed frame loading,
// fht_control handshake, start retry and mid-frame reset.
module tb_fht_input_loader;

    localparam int AB = 8;
    localparam int DB = 16;
    localparam int NF = 1024;

    logic          clk = 1'b0;
    logic          iRESET;
    logic [DB-1:0] iDATA;
    logic          iVALID;
    logic          oREADY;
    logic          iFHT_RDY;
    logic          oSTART;
    logic [AB-1:0] oADDR;
    logic [DB-1:0] oDATA;
    logic [3:0]    oWE;
    logic          oLOAD_OWN;
    logic          oFRAME_DONE;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_start = 0;
    int start_cyc = -1;
    int n_done = 0;
    int done_cyc = -1;
    int n_wr = 0;
    int first_wr = -1;
    int seen [NF];

    logic [9:0] mn = '0;
    logic [1:0] obs_bank;
    logic [7:0] obs_addr;

    fht_input_loader #(
        .A_BIT (AB),
        .D_BIT (DB)
    ) dut (
        .iCLK        (clk),
        .iRESET      (iRESET),
        .iDATA       (iDATA),
        .iVALID      (iVALID),
        .oREADY      (oREADY),
        .iFHT_RDY    (iFHT_RDY),
        .oSTART      (oSTART),
        .oADDR       (oADDR),
        .oDATA       (oDATA),
        .oWE         (oWE),
        .oLOAD_OWN   (oLOAD_OWN),
        .oFRAME_DONE (oFRAME_DONE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    task automatic clear_cov();
        foreach (seen[i]) seen[i] = 0;
        n_wr = 0;
        first_wr = -1;
    endtask

    task automatic check_cov();
        int bad;
        bad = 0;
        foreach (seen[i]) if (seen[i] != 1) bad++;
        check("cover_once", bad, 0);
        check("wr_count", n_wr, NF);
    endtask

    // One clock: drive inputs, step, check the write bus against the model.
    task automatic cyc_step(input logic rst, input logic v,
                            input logic [DB-1:0] d, input logic frdy,
                            output logic acc);
        logic [9:0] r;
        iRESET = rst;
        iVALID = v;
        iDATA = d;
        iFHT_RDY = frdy;
        acc = rst & v & oREADY;
        r = rev10(mn);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (oSTART) begin
            n_start++;
            start_cyc = cyc;
        end
        if (oFRAME_DONE) begin
            n_done++;
            done_cyc = cyc;
        end
        if (acc) begin
            check("we", oWE, 4'b0001 << r[9:8]);
            check("addr", oADDR, r[7:0]);
            check("data", oDATA, d);
            check("own_on_write", oLOAD_OWN, 1);
            obs_bank = oWE[3] ? 2'd3 : oWE[2] ? 2'd2 : oWE[1] ? 2'd1 : 2'd0;
            obs_addr = oADDR;
            seen[{obs_bank, obs_addr}]++;
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            mn = mn + 10'd1;
        end else begin
            check("we_idle", oWE, 0);
        end
        if (!rst) mn = '0;
    endtask

    task automatic stream(input int count, input int gap, input int base,
                          input int spot, output int last);
        int i;
        int g;
        logic acc;
        logic v;
        i = 0;
        g = 0;
        last = -1;
        while (i < count && g < 6000) begin
            v = ($urandom_range(0, 99) >= gap);
            cyc_step(1'b1, v, DB'(base + i), 1'b1, acc);
            if (acc) begin
                last = cyc - 1;
                if (spot == 1 && i == 1) check("map_n1", {obs_bank, obs_addr}, {2'd2, 8'd0});
                if (spot == 1 && i == 4) check("map_n4", {obs_bank, obs_addr}, {2'd0, 8'd128});
                if (spot == 1 && i == 1023) check("map_n1023", {obs_bank, obs_addr}, {2'd3, 8'd255});
                if (spot == 2 && i == 0) check("map_after_rst", {obs_bank, obs_addr}, {2'd0, 8'd0});
                i++;
            end
            g++;
        end
        check("stream_complete", i, count);
    endtask

    task automatic wait_start(input int last);
        int g;
        int ns0;
        logic acc;
        g = 0;
        ns0 = n_start;
        while (n_start == ns0 && g < 10) begin
            cyc_step(1'b1, 1'b1, '0, 1'b1, acc);
            g++;
        end
        check("start_seen", n_start - ns0, 1);
        check("start_latency", start_cyc - last, 2);
        check("own_kick", oLOAD_OWN, 0);
    endtask

    task automatic finish_frame();
        int g;
        int nd;
        logic acc;
        cyc_step(1'b1, 1'b0, '0, 1'b1, acc);
        repeat (3) cyc_step(1'b1, 1'b0, '0, 1'b0, acc);
        nd = n_done;
        g = 0;
        while (n_done == nd && g < 5) begin
            cyc_step(1'b1, 1'b0, '0, 1'b1, acc);
            g++;
        end
        check("hs_done", n_done - nd, 1);
        check("hs_rdy", oREADY, 1);
    endtask

    initial begin
        int last;
        int s;
        int ns;
        int nd;
        int d;
        int prev;
        logic acc;
        iRESET = 1'b0;
        iVALID = 1'b0;
        iDATA = '0;
        iFHT_RDY = 1'b1;
        @(negedge clk);

        // Reset state
        cyc_step(1'b0, 1'b0, '0, 1'b1, acc);
        check("rst_ready", oREADY, 0);
        check("rst_start", oSTART, 0);
        check("rst_addr", oADDR, 0);
        check("rst_data", oDATA, 0);
        check("rst_own", oLOAD_OWN, 1);
        check("rst_done", oFRAME_DONE, 0);
        cyc_step(1'b1, 1'b0, '0, 1'b1, acc);
        check("ready_after_rst", oREADY, 1);

        // Full frame, iVALID held high
        clear_cov();
        stream(NF, 0, 0, 1, last);
        check_cov();
        check("ready_fire", oREADY, 0);
        wait_start(last);

        // fht_control busy for 5000 cycles; input kept valid
        ns = n_start;
        nd = n_done;
        cyc_step(1'b1, 1'b1, 16'hbeef, 1'b1, acc);
        repeat (5000) begin
            cyc_step(1'b1, 1'b1, 16'hbeef, 1'b0, acc);
            check("ready_busy", oREADY, 0);
            check("own_busy", oLOAD_OWN, 0);
        end
        check("no_restart", n_start, ns);
        check("no_early_done", n_done, nd);
        cyc_step(1'b1, 1'b1, 16'h1000, 1'b1, acc);
        check("frame_done", oFRAME_DONE, 1);
        check("done_ready", oREADY, 1);
        check("done_own", oLOAD_OWN, 1);
        d = done_cyc;

        // Back-to-back second frame
        clear_cov();
        stream(NF, 0, 16'h1000, 0, last);
        check("done_once", n_done - nd, 1);
        check("fw_after_done", first_wr > d, 1);
        check_cov();
        wait_start(last);

        // fht_control never responds: start retries every 4 cycles
        s = start_cyc;
        ns = n_start;
        prev = s;
        for (int k = 0; k < 20; k++) begin
            cyc_step(1'b1, 1'b1, '0, 1'b1, acc);
            check("ready_retry", oREADY, 0);
            if (oSTART) begin
                check("retry_gap", cyc - prev, 4);
                prev = cyc;
            end
        end
        check("retry_count", n_start - ns, 5);
        check("retry_last", start_cyc, s + 20);

        // Reset out of WAIT_BUSY, then a frame with 30% idle gaps
        cyc_step(1'b0, 1'b1, '0, 1'b1, acc);
        check("rst2_own", oLOAD_OWN, 1);
        check("rst2_start", oSTART, 0);
        check("rst2_ready", oREADY, 0);
        clear_cov();
        stream(NF, 30, 16'h2000, 0, last);
        check_cov();
        wait_start(last);
        finish_frame();

        // Reset after 500 samples: partial frame discarded
        stream(500, 0, 16'h3000, 0, last);
        ns = n_start;
        cyc_step(1'b0, 1'b1, '0, 1'b1, acc);
        check("rst3_own", oLOAD_OWN, 1);
        check("rst3_start", oSTART, 0);
        check("rst3_ready", oREADY, 0);
        stream(NF, 0, 16'h4000, 2, last);
        check("no_start_early", n_start, ns);
        wait_start(last);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fht_input_loader.md
Name: fht_input_loader

Overview:
Upstream stage of fht_control. Accepts a stream of N = 4*2^A_BIT real samples over a valid/ready handshake and writes each sample into one of the four bank RAMs at its bit-reversed position. After the last write lands it pulses the start input of fht_control. It then holds off new input until fht_control signals completion of the transform.

Parameters:
A_BIT, 8, bank address width; bank size 2^A_BIT, frame length N = 4*2^A_BIT (1024 at default)
D_BIT, 16, sample width (two's complement, passed through unchanged)

Ports:
iCLK  in  1  clock
iRESET  in  1  synchronous active-low reset
iDATA  in  D_BIT  input sample
iVALID  in  1  sample valid
oREADY  out  1  loader accepts sample this cycle
iFHT_RDY  in  1  oRDY from fht_control (1 = idle/done)
oSTART  out  1  one-cycle start pulse to fht_control iSTART
oADDR  out  A_BIT  bank write address, common to all banks
oDATA  out  D_BIT  bank write data
oWE  out  4  per-bank write enable, one-hot or zero
oLOAD_OWN  out  1  1 = loader owns bank write ports (drives the bank input mux)
oFRAME_DONE  out  1  one-cycle pulse when fht_control finishes a loaded frame

Behaviour:
- Clock and reset: one clock, iCLK. Reset is synchronous and active-low on iRESET.
- Reset values: state = LOAD, sample counter n = 0, oREADY = 0, oSTART = 0, oWE = 0, oADDR = 0, oDATA = 0, oLOAD_OWN = 1, oFRAME_DONE = 0.
- oREADY is registered. It is 1 in LOAD from the first cycle after reset deassertion, except in the cycle after the last sample is accepted.
- Accept condition: iVALID & oREADY at a rising edge.
- Address mapping. n is A_BIT+2 bits wide; r = bitreverse(n) over A_BIT+2 bits.
  - Bank b = r[A_BIT+1:A_BIT].
  - oADDR = r[A_BIT-1:0].
- Write latency: 1 cycle. A sample accepted at edge k drives oWE[b] = 1, oADDR and oDATA during cycle k+1.
- Any cycle with no accept has oWE = 0. oADDR and oDATA hold their last values.
- Counter n increments on accept and wraps N-1 -> 0.
- States:
  - LOAD: accept samples. On accepting n = N-1, drop oREADY and go to FIRE.
  - FIRE: the last write is on the bus this cycle. Go to KICK.
  - KICK: oSTART = 1 for exactly one cycle, oLOAD_OWN = 0. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for iFHT_RDY = 0, then go to WAIT_DONE. If iFHT_RDY is still 1 after 4 cycles, re-pulse oSTART once and keep waiting.
  - WAIT_DONE: wait for iFHT_RDY = 1. On that, pulse oFRAME_DONE for one cycle, set oLOAD_OWN = 1 and oREADY = 1, and go to LOAD.
- oLOAD_OWN is 0 from KICK through WAIT_DONE inclusive. oWE must never be nonzero while oLOAD_OWN = 0.
- iVALID outside LOAD is ignored. Data is held upstream by oREADY = 0.
- Reset mid-frame: partial frame discarded, n = 0, no oSTART issued, oLOAD_OWN = 1 the cycle after reset deasserts.
- Glitch on iFHT_RDY during WAIT_DONE: a 1 is sampled as done. Requirement on fht_control: oRDY is glitch-free (registered).

Decomposition:
- Shared package fht_pkg:
  - loader state enum {LOAD, FIRE, KICK, WAIT_BUSY, WAIT_DONE}
  - localparam N = 4<<A_BIT
  - function bitrev(n)
  - START_RETRY = 4
- One sub-module, fht_bitrev_map: combinational n -> {bank, addr}.
  - Shared with the output unloader stage that reads results back.

Test Plan:
1. Reset, then stream n = 0..1023 with iDATA = n and iVALID held high:
   - n = 1 writes bank 2, addr 0; n = 4 writes bank 0, addr 128; n = 1023 writes bank 3, addr 255.
   - Every (bank, addr) is written exactly once.
   - oSTART pulses exactly 2 cycles after the last accept.
2. Random iVALID gaps (30% idle) over a full frame:
   - oWE count = 1024, no write in idle cycles, mapping identical to scenario 1.
3. Model fht_control with iFHT_RDY dropping 2 cycles after oSTART and rising 5000 cycles later:
   - oREADY = 0 and oLOAD_OWN = 0 throughout.
   - oFRAME_DONE pulses once; oREADY = 1 on the following cycle.
4. iFHT_RDY never drops:
   - oSTART re-pulses every 4 cycles.
   - State stays WAIT_BUSY; no writes occur.
5. Assert iRESET = 0 for 1 cycle after 500 samples:
   - oWE = 0; the next accepted sample writes at bitreverse(0) = bank 0, addr 0.
   - No oSTART until 1024 further samples.
6. Back-to-back frames with iVALID always high:
   - The second frame's first write occurs only after oFRAME_DONE.
   - oLOAD_OWN = 1 on every write cycle.
